v2f_wide_arith: RTL and testbench

Sequential multi-limb arithmetic/compare unit for operands wider than the 32-bit combinator datapath. Splits WIDTH-bit operands into LIMB-bit limbs. Processes one limb per clock, LSB first, carrying and borrowing between limbs. Instantiated in place of the single-word add/sub/bitwise/compare primitives when any operand exceeds 32 bits, behind a valid/ready handshake.

---
 rtl/v2f_wide_arith.sv | 159 +++++++++++++++
 tb/tb_v2f_wide_arith.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v2f_wide_arith.sv
// v2f_wide_arith: multi-limb add/sub/bitwise/compare unit, one LIMB-bit limb per clock, LSB first.
// Define V2F_WIDE_ARITH_SIGNED_EN to enable signed lt/ge when op_signed=1.
module v2f_wide_arith #(
  parameter int WIDTH = 64,
  parameter int LIMB  = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry
);
  localparam int NLIMB = (WIDTH + LIMB - 1) / LIMB;
  localparam int PW    = NLIMB * LIMB;
  localparam int REM   = WIDTH % LIMB;
  localparam int KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_GE  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [PW-1:0]       a_sh, b_sh;
  logic [PW-LIMB-1:0]  res;
  logic [KW-1:0]       k;
  logic                c, eq_acc;
  logic [2:0]          op_r;
  logic                last, is_sub, sub_in;
  logic [LIMB-1:0]     a_k, b_k, b_op, limb;
  logic [LIMB:0]       s;
  logic [PW-1:0]       res_nx;
  logic                cout, borrow, eq_nx, lt, flag;

`ifdef V2F_WIDE_ARITH_SIGNED_EN
  logic sgn_r, sa_r, sb_r;
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign a_k    = a_sh[LIMB-1:0];
  assign b_k    = b_sh[LIMB-1:0];
  assign last   = (k == KW'(NLIMB - 1));
  assign is_sub = (op_r == OP_SUB) || (op_r == OP_LT) || (op_r == OP_GE);
  assign sub_in = (op == OP_SUB) || (op == OP_LT) || (op == OP_GE);

  always_comb begin
    b_op = is_sub ? ~b_k : b_k;
    s    = {1'b0, a_k} + {1'b0, b_op} + {{LIMB{1'b0}}, c};
    case (op_r)
      OP_AND:  limb = a_k & b_k;
      OP_OR:   limb = a_k | b_k;
      OP_XOR:  limb = a_k ^ b_k;
      default: limb = s[LIMB-1:0];
    endcase
    // Top limb is zero-padded; for sub the padding becomes ones, so sum bit REM is the inverted carry.
    if (REM == 0)   cout = s[LIMB];
    else if (is_sub) cout = ~s[REM];
    else            cout = s[REM];
    borrow = ~cout;
    eq_nx  = eq_acc & (a_k == b_k);
`ifdef V2F_WIDE_ARITH_SIGNED_EN
    lt = (sgn_r && (sa_r != sb_r)) ? sa_r : borrow;
`else
    lt = borrow;
`endif
    case (op_r)
      OP_EQ:   flag = eq_nx;
      OP_LT:   flag = lt;
      OP_GE:   flag = ~lt;
      default: flag = 1'b0;
    endcase
    res_nx = {limb, res};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      k      <= '0;
      c      <= 1'b0;
      eq_acc <= 1'b1;
      op_r   <= OP_ADD;
      y      <= '0;
      carry  <= 1'b0;
`ifdef V2F_WIDE_ARITH_SIGNED_EN
      sgn_r  <= 1'b0;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh   <= PW'(a);
          b_sh   <= PW'(b);
          op_r   <= op;
          k      <= '0;
          c      <= sub_in;
          eq_acc <= 1'b1;
`ifdef V2F_WIDE_ARITH_SIGNED_EN
          sgn_r  <= op_signed;
          sa_r   <= a[WIDTH-1];
          sb_r   <= b[WIDTH-1];
`endif
        end
        RUN: begin
          a_sh   <= a_sh >> LIMB;
          b_sh   <= b_sh >> LIMB;
          res    <= res_nx[PW-1:LIMB];
          c      <= s[LIMB];
          eq_acc <= eq_nx;
          k      <= k + KW'(1);
          if (last) begin
            case (op_r)
              OP_ADD: begin y <= res_nx[WIDTH-1:0]; carry <= cout;   end
              OP_SUB: begin y <= res_nx[WIDTH-1:0]; carry <= borrow; end
              OP_AND, OP_OR, OP_XOR: begin y <= res_nx[WIDTH-1:0]; carry <= 1'b0; end
              default: begin y <= {{(WIDTH-1){1'b0}}, flag}; carry <= 1'b0; end
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_v2f_wide_arith.sv
// Self-checking bench for v2f_wide_arith: 64/31 instance driven from a vector table through a
// scoreboard queue, plus a 40/31 instance for padded-limb corner cases.
module tb_v2f_wide_arith;
  localparam int NL   = 3;
  localparam int NL40 = 2;
`ifdef V2F_WIDE_ARITH_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid40, out_ready, op_signed;
  logic [2:0]  op;
  logic [63:0] a, b, y;
  logic        in_ready, out_valid, carry;
  logic [39:0] a40, b40, y40;
  logic        in_ready40, out_valid40, carry40;

  always #5 clk = ~clk;

  assign a40 = a[39:0];
  assign b40 = b[39:0];

  v2f_wide_arith #(.WIDTH(64), .LIMB(31)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op_signed(op_signed), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry));

  v2f_wide_arith #(.WIDTH(40), .LIMB(31)) dut40 (
    .clk(clk), .rst(rst), .in_valid(in_valid40), .in_ready(in_ready40), .op(op),
    .op_signed(op_signed), .a(a40), .b(b40), .out_valid(out_valid40), .out_ready(out_ready),
    .y(y40), .carry(carry40));

  typedef struct {
    logic [2:0]  op;
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] y;
    logic        c;
  } vec_t;

  typedef struct {
    logic [63:0] y;
    logic        c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic s,
                                 input logic [63:0] x, input logic [63:0] z);
    exp_t        e;
    logic [64:0] t;
    logic        lt;
    e.y = '0;
    e.c = 1'b0;
    lt  = (SGN_EN && s) ? ($signed(x) < $signed(z)) : (x < z);
    case (o)
      3'd0: begin t = {1'b0, x} + {1'b0, z}; e.y = t[63:0]; e.c = t[64]; end
      3'd1: begin e.y = x - z; e.c = (x < z); end
      3'd2: e.y = x & z;
      3'd3: e.y = x | z;
      3'd4: e.y = x ^ z;
      3'd5: e.y = {63'd0, x == z};
      3'd6: e.y = {63'd0, lt};
      default: e.y = {63'd0, !lt};
    endcase
    return e;
  endfunction

  function automatic vec_t mk(input logic [2:0] o, input logic s, input logic [63:0] x,
                              input logic [63:0] z, input logic [63:0] ey, input logic ec);
    vec_t v;
    v.op = o; v.sgn = s; v.a = x; v.b = z; v.y = ey; v.c = ec;
    return v;
  endfunction

  task automatic issue(input logic [2:0] o, input logic s, input logic [63:0] x,
                       input logic [63:0] z, input exp_t e);
    @(negedge clk);
    chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    op = o; op_signed = s; a = x; b = z; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    op = 3'($urandom);
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(NL));
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_out_valid"}, {63'd0, out_valid}, 64'd1);
      chk({nm, "_y"}, y, e.y);
      chk({nm, "_carry"}, {63'd0, carry}, {63'd0, e.c});
    end
  endtask

  task automatic retire(input string nm);
    pop_cmp(nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [63:0] x, z;
    int          lat;
    logic [2:0]  op40[4];
    logic        sg40[4];
    logic [39:0] a40v[4], b40v[4], y40v[4];
    logic        c40v[4];

    rst = 1'b1; in_valid = 1'b0; in_valid40 = 1'b0; out_ready = 1'b0;
    op = 3'd0; op_signed = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_y",         y,                  64'd0);
    chk("reset_carry",     {63'd0, carry},     64'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk(3'd0, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'h0000_0000_8000_0000, 1'b0));
    vecs.push_back(mk(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1));
    vecs.push_back(mk(3'd1, 1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
    vecs.push_back(mk(3'd1, 1'b0, 64'd5, 64'd3, 64'd2, 1'b0));
    vecs.push_back(mk(3'd6, 1'b0, 64'd0, 64'd1, 64'd1, 1'b0));
    vecs.push_back(mk(3'd7, 1'b0, 64'd0, 64'd1, 64'd0, 1'b0));
    vecs.push_back(mk(3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, {63'd0, SGN_EN}, 1'b0));
    vecs.push_back(mk(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0));
    vecs.push_back(mk(3'd7, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 1'b0));
    vecs.push_back(mk(3'd5, 1'b0, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'd0, 1'b0));
    vecs.push_back(mk(3'd2, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0));
    for (int i = 0; i < 16; i++) begin
      x = {$urandom, $urandom};
      z = (i % 4 == 0) ? x : {$urandom, $urandom};
      e = model(3'(i), 1'(i / 8), x, z);
      vecs.push_back(mk(3'(i), 1'(i / 8), x, z, e.y, e.c));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      e.y = vecs[i].y;
      e.c = vecs[i].c;
      issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, e);
      wait_valid($sformatf("vec%0d", i));
      retire($sformatf("vec%0d", i));
    end

    // Reset in the middle of RUN discards the partial result.
    e.y = 64'h30; e.c = 1'b0;
    issue(3'd0, 1'b0, 64'h10, 64'h20, e);
    wait_valid("pre_rst");
    retire("pre_rst");
    e.y = 64'h11; e.c = 1'b0;
    issue(3'd0, 1'b0, 64'h5, 64'hC, e);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rstmid_y",         y,                  64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    e.y = 64'h1_FFFF_FFFF; e.c = 1'b0;
    issue(3'd0, 1'b0, 64'h1_0000_0000, 64'hFFFF_FFFF, e);
    wait_valid("post_rst");
    retire("post_rst");

    // Backpressure: result held while out_ready stays low; new requests ignored.
    e.y = 64'd1; e.c = 1'b0;
    issue(3'd5, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, e);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = (i >= 2 && i < 5);
      op = 3'd0; a = 64'd7; b = 64'd9;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp_hold%0d_y", i), y, 64'd1);
      chk($sformatf("bp_hold%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    retire("bp");
    repeat (4) @(posedge clk);
    #1;
    chk("bp_ignored_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_ignored_in_ready",  {63'd0, in_ready},  64'd1);

    // out_ready already high on entry to DONE: one-cycle DONE.
    out_ready = 1'b1;
    e.y = 64'hFFFF_FFFF_FFFF_FFFE; e.c = 1'b1;
    issue(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, e);
    wait_valid("early_rdy");
    pop_cmp("early_rdy");
    @(posedge clk);
    #1;
    chk("early_rdy_in_ready",  {63'd0, in_ready},  64'd1);
    chk("early_rdy_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    // WIDTH=40: top limb carries 9 real bits and 22 padding bits.
    op40[0] = 3'd4; sg40[0] = 1'b0; a40v[0] = 40'hFF_0000_FFFF; b40v[0] = 40'h0F_F0F0_F0F0;
    y40v[0] = 40'hF0_F0F0_0F0F; c40v[0] = 1'b0;
    op40[1] = 3'd0; sg40[1] = 1'b0; a40v[1] = 40'hFF_FFFF_FFFF; b40v[1] = 40'd1;
    y40v[1] = 40'd0; c40v[1] = 1'b1;
    op40[2] = 3'd1; sg40[2] = 1'b0; a40v[2] = 40'd0; b40v[2] = 40'd1;
    y40v[2] = 40'hFF_FFFF_FFFF; c40v[2] = 1'b1;
    op40[3] = 3'd6; sg40[3] = 1'b1; a40v[3] = 40'h80_0000_0000; b40v[3] = 40'd1;
    y40v[3] = {39'd0, SGN_EN}; c40v[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op = op40[i]; op_signed = sg40[i];
      a = {24'd0, a40v[i]}; b = {24'd0, b40v[i]};
      in_valid40 = 1'b1;
      @(posedge clk);
      #1;
      in_valid40 = 1'b0;
      a = {$urandom, $urandom};
      lat = 0;
      while (!out_valid40 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("w40_%0d_latency", i), 64'(lat), 64'(NL40));
      chk($sformatf("w40_%0d_y", i), {24'd0, y40}, {24'd0, y40v[i]});
      chk($sformatf("w40_%0d_carry", i), {63'd0, carry40}, {63'd0, c40v[i]});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk($sformatf("w40_%0d_in_ready", i), {63'd0, in_ready40}, 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
